// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl
// Sequencing controller for the snake position datapath: decodes keyboard
// keycodes into a committed direction, paces movement with a frame-divided
// step strobe, runs timed pushback episodes on obstacle contact and supports
// pause/resume on the space key.
//
// Build option: define SNAKE_REVERSE_GUARD_EN to reject direction keys that
// would reverse the snake while it is running. Left undefined, every
// direction key is accepted in RUN and a reversal commits at the next step.
`timescale 1ns/1ps

module snake_motion_ctrl #(
   parameter int unsigned STEP_DIV   = 4,
   parameter int unsigned HIT_FRAMES = 8,
   parameter logic [1:0]  DIR_INIT   = 2'b11
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [15:0] keycode,
   input  logic        OB1Flag,
   output logic        step_en,
   output logic [1:0]  motionFlag,
   output logic        pushback,
   output logic [1:0]  state,
   output logic [3:0]  hit_count,
   output logic [9:0]  LEDR
);

   // Counter widths; a divider or episode length of 1 still needs one bit.
   localparam int unsigned CW = (STEP_DIV > 1)   ? $clog2(STEP_DIV)   : 1;
   localparam int unsigned TW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
   localparam logic [TW-1:0] TMR_ZERO = TW'(1'b0);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1'b1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(HIT_FRAMES - 1);

   // Keyboard usage codes of interest.
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      HIT   = 2'b11
   } state_t;

   // Returns {valid, direction} for one keycode slot.
   function automatic logic [2:0] decode_dir(input logic [7:0] code);
      logic [2:0] result;
      case (code)
         KEY_W:   result = 3'b1_00;
         KEY_A:   result = 3'b1_01;
         KEY_S:   result = 3'b1_10;
         KEY_D:   result = 3'b1_11;
         default: result = 3'b0_00;
      endcase
      return result;
   endfunction

   // Opposite directions differ only in the upper bit of the encoding.
   function automatic logic is_reversal(input logic [1:0] dir_a,
                                        input logic [1:0] dir_b);
      return ((dir_a ^ dir_b) == 2'b10);
   endfunction

   // Hit counter increment that sticks at its maximum.
   function automatic logic [3:0] sat_inc(input logic [3:0] value);
      return (value == 4'd15) ? value : (value + 4'd1);
   endfunction

   // Registered state.
   state_t          state_r;
   logic [1:0]      motion_r;
   logic [1:0]      pending_r;
   logic [CW-1:0]   cnt_r;
   logic [TW-1:0]   timer_r;
   logic            step_r;
   logic            push_r;
   logic [3:0]      hits_r;
   logic            space_prev_r;

   // Combinational decode results.
   logic [2:0]      dec_lo_s;
   logic [2:0]      dec_hi_s;
   logic            key_valid_s;
   logic [1:0]      key_dir_s;
   logic            space_s;
   logic            pause_edge_s;
   logic            key_accept_s;
   logic [1:0]      pending_next_s;

   // Pick the direction key, low slot first, high slot only as a fallback.
   always_comb begin
      dec_lo_s    = decode_dir(keycode[7:0]);
      dec_hi_s    = decode_dir(keycode[15:8]);
      key_valid_s = 1'b0;
      key_dir_s   = 2'b00;
      if (dec_lo_s[2]) begin
         key_valid_s = 1'b1;
         key_dir_s   = dec_lo_s[1:0];
      end else begin
         key_valid_s = dec_hi_s[2];
         key_dir_s   = dec_hi_s[1:0];
      end
   end

   // Space in either slot; only its rising edge toggles pause.
   always_comb begin
      space_s      = (keycode[7:0] == KEY_SPACE) || (keycode[15:8] == KEY_SPACE);
      pause_edge_s = space_s & ~space_prev_r;
   end

   // Decide whether a running-state key is taken and what pending becomes.
   always_comb begin
`ifdef SNAKE_REVERSE_GUARD_EN
      key_accept_s = key_valid_s & ~is_reversal(key_dir_s, motion_r);
`else
      key_accept_s = key_valid_s;
`endif
      pending_next_s = pending_r;
      if (key_accept_s) begin
         pending_next_s = key_dir_s;
      end else begin
         pending_next_s = pending_r;
      end
   end

   // Remember last cycle's space level for edge detection in every state.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         space_prev_r <= 1'b0;
      end else begin
         space_prev_r <= space_s;
      end
   end

   // Motion FSM: state, direction, step divider, pushback timer, strobes.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_r   <= IDLE;
         motion_r  <= DIR_INIT;
         pending_r <= DIR_INIT;
         cnt_r     <= CNT_ZERO;
         timer_r   <= TMR_ZERO;
         step_r    <= 1'b0;
         push_r    <= 1'b0;
         hits_r    <= 4'd0;
      end else begin
         // Strobes default low; only RUN wraps and HIT cycles raise them.
         step_r <= 1'b0;
         push_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // First direction key starts motion without a reversal check.
               if (key_valid_s) begin
                  state_r   <= RUN;
                  motion_r  <= key_dir_s;
                  pending_r <= key_dir_s;
                  cnt_r     <= CNT_ZERO;
               end else begin
                  state_r   <= IDLE;
               end
            end

            RUN: begin
               pending_r <= pending_next_s;
               if (OB1Flag) begin
                  // Contact wins over pause and over a step wrap.
                  state_r <= HIT;
                  timer_r <= TMR_LOAD;
                  hits_r  <= sat_inc(hits_r);
                  step_r  <= 1'b1;
                  push_r  <= 1'b1;
               end else if (pause_edge_s) begin
                  // Divider is frozen on the pausing edge so no step leaks out.
                  state_r <= PAUSE;
               end else if (cnt_r == CNT_LAST) begin
                  cnt_r    <= CNT_ZERO;
                  step_r   <= 1'b1;
                  motion_r <= pending_next_s;
               end else begin
                  cnt_r    <= cnt_r + CNT_ONE;
               end
            end

            PAUSE: begin
               // Everything holds; cnt resumes from where it stopped.
               if (pause_edge_s) begin
                  state_r <= RUN;
               end else begin
                  state_r <= PAUSE;
               end
            end

            HIT: begin
               if (timer_r == TMR_ZERO) begin
                  if (OB1Flag) begin
                     // Still touching: extend the episode without recounting.
                     timer_r <= TMR_LOAD;
                     step_r  <= 1'b1;
                     push_r  <= 1'b1;
                  end else begin
                     state_r <= RUN;
                     cnt_r   <= CNT_ZERO;
                  end
               end else begin
                  timer_r <= timer_r - TMR_ONE;
                  step_r  <= 1'b1;
                  push_r  <= 1'b1;
               end
            end

            default: begin
               // Unreachable encoding: recover to a quiet, stopped state.
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
               timer_r <= TMR_ZERO;
            end
         endcase
      end
   end

   assign step_en    = step_r;
   assign pushback   = push_r;
   assign motionFlag = motion_r;
   assign state      = state_r;
   assign hit_count  = hits_r;
   assign LEDR       = {step_r, push_r, hits_r, motion_r, state_r};

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Self-checking bench for snake_motion_ctrl: directed scenarios followed by
// randomized keycodes/obstacle pulses, all compared every cycle against a
// behavioural model of the controller's rules.
`timescale 1ns/1ps

module tb_snake_motion_ctrl;

   localparam int         STEP_DIV   = 4;
   localparam int         HIT_FRAMES = 8;
   localparam logic [1:0] DIR_INIT   = 2'b11;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_HIT   = 3;

   logic        frame_clk = 1'b0;
   logic        Reset;
   logic [15:0] keycode;
   logic        OB1Flag;
   logic        step_en;
   logic [1:0]  motionFlag;
   logic        pushback;
   logic [1:0]  state;
   logic [3:0]  hit_count;
   logic [9:0]  LEDR;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model
   int m_mode, m_phase, m_hit_left, m_dir, m_pend, m_hits;
   bit m_prev_space, m_step, m_push;

   snake_motion_ctrl #(
      .STEP_DIV   (STEP_DIV),
      .HIT_FRAMES (HIT_FRAMES),
      .DIR_INIT   (DIR_INIT)
   ) dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .OB1Flag    (OB1Flag),
      .step_en    (step_en),
      .motionFlag (motionFlag),
      .pushback   (pushback),
      .state      (state),
      .hit_count  (hit_count),
      .LEDR       (LEDR)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int key_dir(input logic [7:0] k);
      case (k)
         8'h1A:   return 0;
         8'h04:   return 1;
         8'h16:   return 2;
         8'h07:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_phase = 0; m_hit_left = 0;
      m_dir = int'(DIR_INIT); m_pend = int'(DIR_INIT);
      m_hits = 0; m_prev_space = 1'b0; m_step = 1'b0; m_push = 1'b0;
   endtask

   task automatic model_edge(input logic [15:0] kc, input logic ob);
      int  d;
      bit  sp, pedge, accepted;
      d = key_dir(kc[7:0]);
      if (d < 0) d = key_dir(kc[15:8]);
      sp = (kc[7:0] == 8'h2C) || (kc[15:8] == 8'h2C);
      pedge = sp && !m_prev_space;
      m_prev_space = sp;
      m_step = 1'b0;
      m_push = 1'b0;
      case (m_mode)
         M_IDLE: begin
            if (d >= 0) begin
               m_mode = M_RUN; m_dir = d; m_pend = d; m_phase = 0;
            end
         end
         M_RUN: begin
`ifdef SNAKE_REVERSE_GUARD_EN
            accepted = (d >= 0) && ((d ^ m_dir) != 2);
`else
            accepted = (d >= 0);
`endif
            if (accepted) m_pend = d;
            if (ob) begin
               m_mode = M_HIT; m_hit_left = HIT_FRAMES;
               m_hits = (m_hits < 15) ? m_hits + 1 : 15;
               m_step = 1'b1; m_push = 1'b1;
            end else if (pedge) begin
               m_mode = M_PAUSE;
            end else begin
               m_phase++;
               if (m_phase == STEP_DIV) begin
                  m_phase = 0; m_step = 1'b1; m_dir = m_pend;
               end
            end
         end
         M_PAUSE: begin
            if (pedge) m_mode = M_RUN;
         end
         default: begin
            m_hit_left--;
            if (m_hit_left == 0) begin
               if (!ob) begin
                  m_mode = M_RUN; m_phase = 0;
               end else begin
                  m_hit_left = HIT_FRAMES; m_step = 1'b1; m_push = 1'b1;
               end
            end else begin
               m_step = 1'b1; m_push = 1'b1;
            end
         end
      endcase
   endtask

   task automatic check_model();
      logic [1:0] em, ed;
      logic [3:0] eh;
      logic [9:0] el;
      em = 2'(m_mode);
      ed = 2'(m_dir);
      eh = 4'(m_hits);
      el = {m_step, m_push, eh, ed, em};
      check("state", 16'(state), 16'(em));
      check("motionFlag", 16'(motionFlag), 16'(ed));
      check("step_en", 16'(step_en), 16'(m_step));
      check("pushback", 16'(pushback), 16'(m_push));
      check("hit_count", 16'(hit_count), 16'(eh));
      check("LEDR", 16'(LEDR), 16'(el));
   endtask

   task automatic tick(input logic [15:0] kc, input logic ob);
      keycode = kc;
      OB1Flag = ob;
      @(posedge frame_clk);
      if (Reset) model_reset();
      else model_edge(kc, ob);
      #1;
      check_model();
   endtask

   function automatic logic [7:0] pick_code();
      logic [7:0] r;
      case ($urandom_range(0, 11))
         0:       r = 8'h1A;
         1:       r = 8'h04;
         2:       r = 8'h16;
         3:       r = 8'h07;
         4, 5:    r = 8'h2C;
         6:       r = 8'($urandom_range(0, 255));
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   initial begin
      int         pcount;
      logic [9:0] reset_led;
      logic [15:0] kc;
      logic        ob;
      reset_led = 10'h00C;

      // Reset
      Reset = 1'b0; keycode = 16'h0000; OB1Flag = 1'b0;
      model_reset();
      #1 Reset = 1'b1;
      #1;
      check_model();
      check("reset_LEDR", 16'(LEDR), 16'(reset_led));
      tick(16'h0000, 1'b0);
      tick(16'h0000, 1'b0);
      Reset = 1'b0;

      // IDLE ignores space and obstacle
      tick(16'h002C, 1'b0);
      tick(16'h0000, 1'b1);
      check("idle_ignores", 16'(state), 16'd0);

      // Start with W; steps after k+4, k+8, k+12
      tick(16'h001A, 1'b0);
      check("start_dir", 16'(motionFlag), 16'd0);
      for (int i = 1; i <= 12; i++) begin
         tick(16'h0000, 1'b0);
         check("step_timing", 16'(step_en), 16'((i % 4) == 0));
      end

      // Turn right, then try a reversal to left, then down
      tick(16'h0007, 1'b0);
      for (int i = 0; i < 3; i++) tick(16'h0000, 1'b0);
      check("dir_D", 16'(motionFlag), 16'd3);
      tick(16'h0004, 1'b0);
      for (int i = 0; i < 3; i++) tick(16'h0000, 1'b0);
`ifdef SNAKE_REVERSE_GUARD_EN
      check("reversal", 16'(motionFlag), 16'd3);
`else
      check("reversal", 16'(motionFlag), 16'd1);
`endif
      tick(16'h0016, 1'b0);
      for (int i = 0; i < 3; i++) tick(16'h0000, 1'b0);
      check("dir_S", 16'(motionFlag), 16'd2);

      // One-cycle obstacle: 8 pushback cycles then RUN
      tick(16'h0000, 1'b1);
      pcount = int'(pushback);
      for (int i = 0; i < 11; i++) begin
         tick(16'h0000, 1'b0);
         pcount += int'(pushback);
      end
      check("hit_len", 16'(pcount), 16'(HIT_FRAMES));
      check("hit_one", 16'(hit_count), 16'd1);
      check("hit_exit", 16'(state), 16'd1);

      // Held obstacle extends HIT, counted once
      for (int i = 0; i < 20; i++) tick(16'h0000, 1'b1);
      check("hit_hold_state", 16'(state), 16'd3);
      for (int i = 0; i < 10; i++) tick(16'h0000, 1'b0);
      check("hit_hold_count", 16'(hit_count), 16'd2);
      check("hit_hold_exit", 16'(state), 16'd1);

      // Space held 5 cycles: one pause, no steps
      pcount = 0;
      for (int i = 0; i < 5; i++) begin
         tick(16'h002C, 1'b0);
         pcount += int'(step_en);
      end
      check("pause_steps", 16'(pcount), 16'd0);
      check("pause_state", 16'(state), 16'd2);
      tick(16'h0000, 1'b0);
      tick(16'h0000, 1'b0);
      tick(16'h2C00, 1'b0);
      check("resume_state", 16'(state), 16'd1);
      for (int i = 0; i < 6; i++) tick(16'h0000, 1'b0);

      // Space and obstacle together -> HIT
      tick(16'h002C, 1'b1);
      check("space_ob", 16'(state), 16'd3);
      for (int i = 0; i < 10; i++) tick(16'h0000, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         kc = {pick_code(), pick_code()};
         ob = ($urandom_range(0, 39) == 0);
         tick(kc, ob);
      end

      // Reset in the middle of a pushback episode
      tick(16'h0000, 1'b0);
      tick(16'h0000, 1'b1);
      tick(16'h0000, 1'b0);
      #2 Reset = 1'b1;
      model_reset();
      #1;
      check_model();
      check("midhit_LEDR", 16'(LEDR), 16'(reset_led));
      tick(16'h0000, 1'b0);
      Reset = 1'b0;

      // Low slot wins over high slot after restart
      tick(16'h1A04, 1'b0);
      check("slot_priority", 16'(motionFlag), 16'd1);
      for (int i = 0; i < 10; i++) tick(16'h0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/snake_motion_ctrl.md
# snake_motion_ctrl

Sequencing controller for the snake position datapath. It turns raw keyboard keycodes into a committed direction and paces movement with a frame-divided step strobe. On obstacle contact it runs a timed pushback episode, and it supports pause/resume. It sits between the USB keycode source and the snake position register, driving its step enable, `motionFlag` and pushback controls.

## Interface
Parameters:
- `STEP_DIV`, default 4: frames per movement step; legal range ≥1.
- `HIT_FRAMES`, default 8: length of a pushback episode, in frames; legal range ≥1.
- `DIR_INIT`, default 2'b11: direction after reset.

Ports:
- `frame_clk`  in  1  frame clock; all state changes on its rising edge.
- `Reset`  in  1  reset, asynchronous, active-high.
- `keycode`  in  16  two keycode slots, `[7:0]` and `[15:8]`.
- `OB1Flag`  in  1  obstacle contact, level.
- `step_en`  out  1  one-cycle strobe; the datapath moves one pixel.
- `motionFlag`  out  2  committed direction: 00=W (up), 01=A (left), 10=S (down), 11=D (right).
- `pushback`  out  1  when high, the datapath moves opposite to `motionFlag` on `step_en`.
- `state`  out  2  00=IDLE, 01=RUN, 10=PAUSE, 11=HIT.
- `hit_count`  out  4  obstacle hits, saturating.
- `LEDR`  out  10  status mirror: `{step_en, pushback, hit_count, motionFlag, state}`.

## Operation
- Key decode:
  - Direction keys: 8'h1A→00, 8'h04→01, 8'h16→10, 8'h07→11.
  - Slot `[7:0]` has priority; slot `[15:8]` is used only if `[7:0]` holds no direction key.
  - Space (8'h2C) in either slot is the pause key. It is edge-detected: it acts only on a cycle where it is present and was absent the previous cycle.
- `pending_dir` register:
  - Loaded in RUN with any accepted direction key.
  - A key that is opposite the committed `motionFlag` (XOR == 2'b10) is rejected, subject to Configuration.
- Step divider `cnt` runs 0..STEP_DIV-1 in RUN only.
- FSM states:
  - **IDLE**: no strobes.
    - A direction key goes to RUN. `motionFlag` and `pending_dir` are set to that key's direction, with no reversal check. `cnt` is set to 0.
    - Space and `OB1Flag` are ignored.
  - **RUN**:
    - When `cnt == STEP_DIV-1`: `cnt` goes to 0, `step_en` is pulsed, and `motionFlag` is loaded with the next-state value of `pending_dir` (a key accepted this same cycle is included).
    - Otherwise `cnt` increments.
    - `OB1Flag` high goes to HIT.
    - A pause edge goes to PAUSE.
  - **PAUSE**: `cnt`, `pending_dir` and `motionFlag` are frozen and there are no strobes. A pause edge returns to RUN with `cnt` retained.
  - **HIT**:
    - On entry, the timer is loaded with HIT_FRAMES-1 and `hit_count` increments, saturating at 15.
    - Every cycle in HIT: `step_en`=1 and `pushback`=1. Keys and space are ignored.
    - When the timer reaches 0: if `OB1Flag` is low, go to RUN with `cnt`=0; if high, reload the timer and stay in HIT (no further `hit_count` increment).
- Simultaneous events in RUN (priority order):
  - `OB1Flag` beats a pause edge. The edge is consumed and has no effect.
  - `OB1Flag` beats a step wrap. No RUN step is issued; `motionFlag` is not committed.
- Reset, at any time including mid-HIT:
  - `state`=IDLE, `motionFlag`=`pending_dir`=DIR_INIT.
  - `cnt`, timer, `step_en`, `pushback` and `hit_count` = 0.
  - Previous-space flag = 0.
  - `LEDR` = `{0,0,0000,DIR_INIT,00}` (0x00C with the default `DIR_INIT`).

## Timing
- All outputs are registered. Each is valid in the cycle after the edge that computes it.
- Entry to RUN at edge k: the first `step_en` is high after edge k+STEP_DIV, then every STEP_DIV cycles. With STEP_DIV=1, `step_en` is high every RUN cycle.
- A newly committed `motionFlag` and the `step_en` that uses it change on the same edge.
- Key-to-direction latency: at most STEP_DIV cycles.
- `OB1Flag` high at edge k gives `state`=HIT, `pushback`=1 and `step_en`=1 from edge k. Pushback lasts HIT_FRAMES cycles minimum.
- A pause edge at edge k gives `state`=PAUSE after edge k. `step_en` is already low in that cycle.

## Configuration
- `SNAKE_REVERSE_GUARD_EN` defined: reversal keys are rejected in RUN.
- Undefined: all four direction keys are accepted in RUN, and a reversal commits at the next step.
- IDLE behaviour is identical either way.

## Test plan
- Reset with defaults → `state`=00, `motionFlag`=11, `hit_count`=0, `step_en`=0, `LEDR`=0x00C.
- Key 8'h1A at edge k from IDLE → `state`=01, `motionFlag`=00 after k; `step_en` pulses after k+4, k+8, k+12.
- In RUN with `motionFlag`=11, present 8'h04 → with the macro, `motionFlag` stays 11; without it, 01 at the next step. Then 8'h16 → `motionFlag`=10 at the next step.
- In RUN, `OB1Flag`=1 for 1 cycle → 8 cycles of `step_en`=`pushback`=1 with `state`=11, `hit_count`=1, then RUN. Holding `OB1Flag` for 20 cycles extends HIT until it clears; `hit_count` stays 1.
- Space held 5 cycles in RUN → PAUSE once with no `step_en`. Release and press again → RUN resumes with `cnt` retained. Space and `OB1Flag` together → HIT.
- Assert `Reset` mid-HIT → all outputs return to reset values immediately.
